dsp_mult_arbiter: RTL

- Shares one in-order pipelined multiplier between PORTS requesters over AXI stream.
- Each requester presents an operand pair (a, b). The block picks one requester per cycle by round-robin and forwards that pair to the multiplier.
- Multiplier results are routed back to the requester that issued them, using an internal tag FIFO that records requester IDs in issue order.
- Sits between requester datapaths (filters, mixers) and a single multiplier instance.

---
 rtl/dsp_mult_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/dsp_mult_arbiter.sv
// dsp_mult_arbiter: round-robin sharing of one in-order pipelined multiplier with tag-based result return
module dsp_mult_arbiter #(
  parameter int WIDTH = 16,
  parameter int PORTS = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS*WIDTH-1:0]     input_a_tdata,
  input  logic [PORTS*WIDTH-1:0]     input_b_tdata,
  input  logic [PORTS-1:0]           input_tvalid,
  output logic [PORTS-1:0]           input_tready,
  output logic [PORTS*2*WIDTH-1:0]   output_tdata,
  output logic [PORTS-1:0]           output_tvalid,
  input  logic [PORTS-1:0]           output_tready,
  output logic [WIDTH-1:0]           mult_a_tdata,
  output logic [WIDTH-1:0]           mult_b_tdata,
  output logic                       mult_tvalid,
  input  logic                       mult_tready,
  input  logic [2*WIDTH-1:0]         mult_res_tdata,
  input  logic                       mult_res_tvalid,
  output logic                       mult_res_tready,
  output logic [$clog2(DEPTH):0]     in_flight,
  output logic                       err_unexpected
);
  localparam int PW = $clog2(PORTS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0] ptr_q, ptr_d, grant, head;
  logic [PW-1:0] tag_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, found, can_issue, issue, non_empty, deliver;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % PORTS);
  endfunction

  // Rotating priority search starting at the round-robin pointer
  always_comb begin
    grant = ptr_q;
    found = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (!found && input_tvalid[wrap(int'(ptr_q) + k)]) begin
        grant = wrap(int'(ptr_q) + k);
        found = 1'b1;
      end
    end
  end

  // Full is judged on the registered count, so a same-cycle delivery cannot free a slot early
  assign can_issue = rst_n & found & (cnt_q < CW'(DEPTH));
  assign issue     = can_issue & mult_tready;
  assign non_empty = cnt_q != '0;
  assign head      = tag_q[rd_q];
  assign deliver   = non_empty & mult_res_tvalid & output_tready[head];

  assign mult_tvalid     = can_issue;
  assign mult_a_tdata    = found ? input_a_tdata[int'(grant)*WIDTH +: WIDTH] : '0;
  assign mult_b_tdata    = found ? input_b_tdata[int'(grant)*WIDTH +: WIDTH] : '0;
  assign input_tready    = issue ? PORTS'(1) << grant : '0;
  assign output_tvalid   = (non_empty & mult_res_tvalid) ? PORTS'(1) << head : '0;
  assign output_tdata    = {PORTS{mult_res_tdata}};
  assign mult_res_tready = non_empty & output_tready[head];
  assign in_flight       = cnt_q;
  assign err_unexpected  = err_q;

  // Next pointer and occupancy
  always_comb begin
    ptr_d = issue ? ((grant == PW'(PORTS - 1)) ? '0 : grant + 1'b1) : ptr_q;
    cnt_d = cnt_q + CW'(issue) - CW'(deliver);
  end

  // Tag storage records the issuing requester in issue order
  always_ff @(posedge clk) begin
    if (issue) tag_q[wr_q] <= grant;
  end

  // Pointer, FIFO indices, occupancy and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (issue) wr_q <= wr_q + 1'b1;
      if (deliver) rd_q <= rd_q + 1'b1;
      if (mult_res_tvalid && !non_empty) err_q <= 1'b1;
    end
  end
endmodule
